// File: rtl/latch_pkg.sv
// rtl/latch_pkg.sv - shared constants and output helper for the latch cells
package latch_pkg;

    localparam int DEFAULT_WIDTH = 1;

    // Reset dominates, then enable selects live data over the held value.
    function automatic logic latch_out(
        input logic rst_n,
        input logic en,
        input logic d,
        input logic held,
        input logic rst_val
    );
        if (!rst_n) begin
            return rst_val;
        end
        return en ? d : held;
    endfunction

endpackage

// File: rtl/d_latch_bit.sv
// rtl/d_latch_bit.sv - single-bit latch cell with a clocked hold register
module d_latch_bit
    import latch_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic d,
    output logic q,
    output logic q_
);

    logic held_q;
    logic held_d;

    always_comb begin
        held_d = en ? d : held_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_q <= RESET_VAL;
        end else begin
            held_q <= held_d;
        end
    end

    // Transparent path bypasses the register so q follows d with no latency.
    assign q  = latch_out(rst_n, en, d, held_q, RESET_VAL);
    assign q_ = ~q;

endmodule

// File: rtl/d_latch.sv
// rtl/d_latch.sv - parameterized D latch emulated with clocked hold registers
module d_latch
    import latch_pkg::*;
#(
    parameter int               WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_
);

    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "d_latch: WIDTH must be at least 1");
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        d_latch_bit #(
            .RESET_VAL (RESET_VAL[i])
        ) u_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .d     (d[i]),
            .q     (q[i]),
            .q_    (q_[i])
        );
    end

endmodule

// File: tb/tb_d_latch.sv
// tb/tb_d_latch.sv - self-checking bench for d_latch at widths 1 and 8
module tb_d_latch;

    localparam logic [7:0] RVB = 8'h3C;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       d1;
    logic [7:0] d8;
    logic       q1, q1_;
    logic [7:0] q8, q8_, qb, qb_;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: value captured at the last rising edge with en=1 out of reset.
    logic       m1;
    logic [7:0] m8;
    logic [7:0] mb;

    always #5 clk = ~clk;

    d_latch #(.WIDTH(1), .RESET_VAL(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .d(d1), .q(q1), .q_(q1_)
    );
    d_latch #(.WIDTH(8), .RESET_VAL(8'h00)) dut8 (
        .clk(clk), .rst_n(rst_n), .en(en), .d(d8), .q(q8), .q_(q8_)
    );
    d_latch #(.WIDTH(8), .RESET_VAL(RVB)) dutb (
        .clk(clk), .rst_n(rst_n), .en(en), .d(d8), .q(qb), .q_(qb_)
    );

    function automatic logic [7:0] model_q(input logic [7:0] din, input logic [7:0] held,
                                           input logic [7:0] rv);
        if (!rst_n) return rv;
        if (en) return din;
        return held;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] e1, e8, eb;
        e1 = model_q({7'b0, d1}, {7'b0, m1}, 8'h00);
        e8 = model_q(d8, m8, 8'h00);
        eb = model_q(d8, mb, RVB);
        chk({tag, ".q1"},  {7'b0, q1},  e1);
        chk({tag, ".q1_"}, {7'b0, q1_}, {7'b0, ~e1[0]});
        chk({tag, ".q8"},  q8,  e8);
        chk({tag, ".q8_"}, q8_, ~e8);
        chk({tag, ".qb"},  qb,  eb);
        chk({tag, ".qb_"}, qb_, ~eb);
        chk({tag, ".q8_is_not_q8"}, q8_ ^ q8, 8'hFF);
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n && en) begin
            m1 = d1;
            m8 = d8;
            mb = d8;
        end
        @(negedge clk);
    endtask

    task automatic set_rst(input logic v);
        rst_n = v;
        if (!v) begin
            m1 = 1'b0;
            m8 = 8'h00;
            mb = RVB;
        end
    endtask

    initial begin
        en = 1'b0; d1 = 1'b0; d8 = 8'h00;
        set_rst(1'b0);
        #1 check_all("reset");
        chk("reset.q8_lit",  q8,  8'h00);
        chk("reset.q8__lit", q8_, 8'hFF);
        tick();

        set_rst(1'b1);
        #1 check_all("release");
        for (int i = 0; i < 10; i++) begin
            tick();
            check_all("hold_zero");
        end

        en = 1'b1; d1 = 1'b0; d8 = 8'h00;
        for (int i = 0; i < 10; i++) begin
            #1 check_all("transp_zero");
            tick();
        end

        en = 1'b0; d1 = 1'b1; d8 = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            #1 check_all("hold_ignores_d");
            tick();
        end

        en = 1'b1; d1 = 1'b1; d8 = 8'hFF;
        #1 check_all("transp_one");
        chk("transp_one.q1_lit", {7'b0, q1}, 8'h01);
        tick();
        en = 1'b0; d1 = 1'b0; d8 = 8'h00;
        #1 check_all("retain_one");
        chk("retain_one.q1_lit", {7'b0, q1}, 8'h01);

        en = 1'b1; d8 = 8'hA5;
        #1 check_all("w8_transp");
        tick();
        en = 1'b0; d8 = 8'h00;
        #1 check_all("w8_hold");
        chk("w8_hold.q8_lit",  q8,  8'hA5);
        chk("w8_hold.q8__lit", q8_, 8'h5A);
        tick();

        en = 1'b1; d1 = 1'b1; d8 = 8'hFF;
        #1 set_rst(1'b0);
        #1 check_all("async_reset");
        chk("async_reset.q8_lit", q8, 8'h00);
        chk("async_reset.qb_lit", qb, RVB);
        tick();
        check_all("reset_wins_edge");
        en = 1'b0;
        set_rst(1'b1);
        #1 check_all("release_rv");
        chk("release_rv.qb_lit", qb, RVB);
        tick();

        en = 1'b1; d8 = 8'h96; d1 = 1'b1;
        tick();
        d8 = 8'h0F; d1 = 1'b0;
        #1 check_all("mid_period_follow");
        #1 en = 1'b0;
        #1 check_all("en_fall_between");
        chk("en_fall_between.q8_lit", q8, 8'h96);
        tick();

        for (int i = 0; i < 200; i++) begin
            set_rst(($urandom_range(0, 11) != 0) ? 1'b1 : 1'b0);
            en = 1'($urandom);
            d1 = 1'($urandom);
            d8 = 8'($urandom);
            #1 check_all("rand_a");
            if ($urandom_range(0, 1) == 1) begin
                #1;
                en = 1'($urandom);
                d1 = 1'($urandom);
                d8 = 8'($urandom);
                #1 check_all("rand_b");
            end
            tick();
            check_all("rand_post_edge");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
